// File: rtl/nes_mem_sched_if.sv
// Loader, NES and SDRAM buses around the memory scheduler.
// master = the surrounding top level, slave = nes_mem_sched.
interface nes_mem_sched_if #(
  parameter int ADDR_W = 22
);
  logic              ld_write;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic              ld_overflow;
  logic [ADDR_W-1:0] nes_addr;
  logic              nes_rd_cpu;
  logic              nes_rd_ppu;
  logic              nes_we;
  logic [7:0]        nes_dout;
  logic              sd_clkref;
  logic [24:0]       sd_addr;
  logic              sd_we;
  logic [7:0]        sd_din;
  logic              sd_oeA;
  logic              sd_oeB;

  modport master (
    output ld_write, ld_addr, ld_data, nes_addr, nes_rd_cpu, nes_rd_ppu, nes_we, nes_dout,
    input  ld_ready, ld_overflow, sd_clkref, sd_addr, sd_we, sd_din, sd_oeA, sd_oeB
  );

  modport slave (
    input  ld_write, ld_addr, ld_data, nes_addr, nes_rd_cpu, nes_rd_ppu, nes_we, nes_dout,
    output ld_ready, ld_overflow, sd_clkref, sd_addr, sd_we, sd_din, sd_oeA, sd_oeB
  );
endinterface

// File: rtl/nes_mem_sched.sv
// NES 4-phase clock-enable and SDRAM port sharing between the ROM loader and the NES core.
// Loader bytes are queued and written one per 4-clock slot; the NES is held in reset until drained.
module nes_mem_sched #(
  parameter int ADDR_W    = 22,
  parameter int FIFO_LOG2 = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           downloading,
  input  logic           ext_reset,
  output logic [1:0]     phase,
  output logic           run_nes,
  output logic           reset_nes,
  nes_mem_sched_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    fifo_addr [DEPTH];
  logic [7:0]           fifo_data [DEPTH];
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2:0]   count;
  logic                 wr_pending;
  logic [ADDR_W-1:0]    wr_addr;
  logic [7:0]           wr_data;
  logic                 overflow;

  logic loader_own, slot_end, fifo_empty, fifo_full;
  logic pop, push, drop, load_entry;

  assign loader_own = (state == LOAD) || (state == DRAIN);
  assign slot_end   = (phase == 2'd3);
  assign fifo_empty = (count == '0);
  // count never exceeds DEPTH, so its MSB alone flags a full FIFO
  assign fifo_full  = count[FIFO_LOG2];
  assign pop        = loader_own && slot_end && !fifo_empty;
  assign push       = loader_own && bus.ld_write && (!fifo_full || pop);
  assign drop       = loader_own && bus.ld_write && !push;
  assign load_entry = ((state == IDLE) || (state == RUN)) && downloading;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase      <= 2'd0;
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      wr_pending <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      phase <= phase + 2'd1;

      if (push) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_LOG2+1)'(1);
        2'b01:   count <= count - (FIFO_LOG2+1)'(1);
        default: count <= count;
      endcase

      if (drop)            overflow <= 1'b1;
      else if (load_entry) overflow <= 1'b0;

      // A popped byte stays on the bus for exactly one slot
      if (!loader_own)   wr_pending <= 1'b0;
      else if (slot_end) wr_pending <= !fifo_empty;

      case (state)
        IDLE:    if (downloading) state <= LOAD;
        LOAD:    if (!downloading) state <= (fifo_empty && !wr_pending) ? RUN : DRAIN;
        DRAIN: begin
          if (downloading)                    state <= LOAD;
          else if (fifo_empty && !wr_pending) state <= RUN;
        end
        RUN:     if (downloading) state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage and the in-flight write carry no reset; ownership gating keeps them off the bus
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.ld_addr;
      fifo_data[wr_ptr] <= bus.ld_data;
    end
    if (pop) begin
      wr_addr <= fifo_addr[rd_ptr];
      wr_data <= fifo_data[rd_ptr];
    end
  end

  assign reset_nes       = (state != RUN) || ext_reset;
  assign run_nes         = slot_end && !reset_nes;
  assign bus.sd_clkref   = phase[1];
  assign bus.ld_ready    = !fifo_full;
  assign bus.ld_overflow = overflow;

  always_comb begin
    bus.sd_addr = '0;
    bus.sd_din  = '0;
    bus.sd_we   = 1'b0;
    bus.sd_oeA  = 1'b0;
    bus.sd_oeB  = 1'b0;
    if (loader_own) begin
      bus.sd_addr = 25'(wr_addr);
      bus.sd_din  = wr_data;
      bus.sd_we   = wr_pending;
    end else if (state == RUN) begin
      bus.sd_addr = 25'(bus.nes_addr);
      bus.sd_din  = bus.nes_dout;
      bus.sd_we   = bus.nes_we;
      bus.sd_oeA  = bus.nes_rd_cpu;
      bus.sd_oeB  = bus.nes_rd_ppu;
    end
  end
endmodule

// File: tb/tb_nes_mem_sched.sv
// Bench for nes_mem_sched: queue-based loader model plus per-scenario checks of the port mux.
module tb_nes_mem_sched;
  localparam int ADDR_W = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, downloading, ext_reset;
  logic [1:0] phase;
  logic       run_nes, reset_nes;

  nes_mem_sched_if #(.ADDR_W(ADDR_W)) bus ();

  nes_mem_sched #(.ADDR_W(ADDR_W), .FIFO_LOG2(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .downloading (downloading),
    .ext_reset   (ext_reset),
    .phase       (phase),
    .run_nes     (run_nes),
    .reset_nes   (reset_nes),
    .bus         (bus)
  );

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         m_fifo[$];
  wr_t         exp_wr[$];
  wr_t         obs_wr[$];
  int unsigned obs_cyc[$];
  int unsigned m_phase;
  int unsigned cyc;
  int unsigned last_slot_cyc;
  bit          m_loader;
  bit          m_ovf;
  logic        prev_we, prev_rn;
  int          n_assert = 0;
  int          n_fail   = 0;

  // One clock: the model reacts to the inputs present at the edge, then outputs are sampled 1ns later.
  task automatic step();
    bit   pop;
    bit   in_reset;
    logic [1:0] mp;
    in_reset = !reset_n;
    if (in_reset) begin
      m_fifo.delete();
      m_ovf = 1'b0;
    end else begin
      pop = (m_phase == 3) && m_loader && (m_fifo.size() > 0);
      if (bus.ld_write && m_loader) begin
        if (m_fifo.size() < 4 || pop) m_fifo.push_back({25'(bus.ld_addr), bus.ld_data});
        else m_ovf = 1'b1;
      end
      if (pop) exp_wr.push_back(m_fifo.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    m_phase = in_reset ? 0 : (m_phase + 1) % 4;
    mp = m_phase[1:0];

    n_assert++;
    if (phase !== mp) begin
      n_fail++;
      $display("FAIL phase: got %0d, expected %0d (cycle %0d)", phase, mp, cyc);
    end
    n_assert++;
    if (bus.sd_clkref !== mp[1]) begin
      n_fail++;
      $display("FAIL sd_clkref: got %b, expected %b", bus.sd_clkref, mp[1]);
    end
    n_assert++;
    if (bus.ld_ready !== (m_fifo.size() < 4)) begin
      n_fail++;
      $display("FAIL ld_ready: got %b, expected %b (cycle %0d)", bus.ld_ready, m_fifo.size() < 4, cyc);
    end
    n_assert++;
    if (bus.ld_overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL ld_overflow: got %b, expected %b (cycle %0d)", bus.ld_overflow, m_ovf, cyc);
    end
    if (prev_rn === 1'b1 && reset_nes === 1'b1 && mp != 2'd0) begin
      n_assert++;
      if (bus.sd_we !== prev_we) begin
        n_fail++;
        $display("FAIL we_hold: sd_we changed mid-slot to %b, expected %b (cycle %0d)", bus.sd_we, prev_we, cyc);
      end
    end
    if (reset_nes === 1'b1 && bus.sd_we === 1'b1 && mp == 2'd0) begin
      obs_wr.push_back({bus.sd_addr, bus.sd_din});
      obs_cyc.push_back(cyc);
      last_slot_cyc = cyc;
    end
    prev_we = bus.sd_we;
    prev_rn = reset_nes;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; downloading = 1'b0; ext_reset = 1'b0;
    bus.ld_write = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.nes_addr = '0; bus.nes_rd_cpu = 1'b0; bus.nes_rd_ppu = 1'b0;
    bus.nes_we = 1'b0; bus.nes_dout = '0;
    m_phase = 0; m_loader = 1'b0; m_ovf = 1'b0; prev_we = 1'b0; prev_rn = 1'b0;
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_assert++;
      if (reset_nes !== 1'b1 || run_nes !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_nes: reset_nes=%b run_nes=%b, expected 1/0", reset_nes, run_nes);
      end
      n_assert++;
      if ({bus.sd_addr, bus.sd_din, bus.sd_we, bus.sd_oeA, bus.sd_oeB} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle_sd: addr=%h din=%h we=%b oeA=%b oeB=%b, expected all 0",
                 bus.sd_addr, bus.sd_din, bus.sd_we, bus.sd_oeA, bus.sd_oeB);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3] = '{8'hA1, 8'hB2, 8'hC3};
    wr_t        want;
    downloading = 1'b1;
    step(); step();
    m_loader = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ld_write = 1'b1;
      bus.ld_addr  = ADDR_W'(32'h10 + i);
      bus.ld_data  = vals[i];
      step();
    end
    bus.ld_write = 1'b0;
    downloading  = 1'b0;
    for (int i = 0; i < 200 && reset_nes !== 1'b0; i++) step();
    n_assert++;
    if (reset_nes !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_run_timeout: reset_nes=%b, expected 0 within 200 clks", reset_nes);
    end
    n_assert++;
    if (obs_wr.size() != 3 || exp_wr.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: observed %0d writes, model %0d, required 3", obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < 3 && i < obs_wr.size(); i++) begin
      want = {25'(32'h10 + i), vals[i]};
      n_assert++;
      if (obs_wr[i] !== want || (i < exp_wr.size() && obs_wr[i] !== exp_wr[i])) begin
        n_fail++;
        $display("FAIL b2b_write%0d: got addr=%h data=%h, expected addr=%h data=%h",
                 i, obs_wr[i].addr, obs_wr[i].data, want.addr, want.data);
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_assert++;
      if (obs_cyc[i] - obs_cyc[i-1] != 4) begin
        n_fail++;
        $display("FAIL b2b_consecutive: slot gap %0d clks, expected 4", obs_cyc[i] - obs_cyc[i-1]);
      end
    end
    n_assert++;
    if (cyc - last_slot_cyc != 5) begin
      n_fail++;
      $display("FAIL b2b_run_entry: RUN %0d clks after last slot start, expected 5", cyc - last_slot_cyc);
    end
    m_loader = 1'b0;
    obs_wr.delete(); obs_cyc.delete(); exp_wr.delete();
  endtask

  task automatic test_run();
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    logic              rc, rp, we;
    for (int i = 0; i < 24; i++) begin
      a  = (i == 0) ? ADDR_W'(32'h12345) : ADDR_W'($urandom);
      rc = (i == 0) ? 1'b1 : 1'($urandom);
      rp = (i == 0) ? 1'b0 : 1'($urandom);
      we = (i == 0) ? 1'b0 : 1'($urandom);
      d  = 8'($urandom);
      bus.nes_addr = a; bus.nes_rd_cpu = rc; bus.nes_rd_ppu = rp;
      bus.nes_we = we; bus.nes_dout = d;
      step();
      n_assert++;
      if (bus.sd_addr !== {3'b000, a} || bus.sd_din !== d || bus.sd_we !== we ||
          bus.sd_oeA !== rc || bus.sd_oeB !== rp) begin
        n_fail++;
        $display("FAIL run_mux: got addr=%h din=%h we=%b oeA=%b oeB=%b, expected addr=%h din=%h we=%b oeA=%b oeB=%b",
                 bus.sd_addr, bus.sd_din, bus.sd_we, bus.sd_oeA, bus.sd_oeB, {3'b000, a}, d, we, rc, rp);
      end
      n_assert++;
      if (reset_nes !== 1'b0 || run_nes !== (m_phase == 3)) begin
        n_fail++;
        $display("FAIL run_ce: reset_nes=%b run_nes=%b, expected 0/%b", reset_nes, run_nes, m_phase == 3);
      end
    end
    bus.nes_we = 1'b0;
    ext_reset  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_assert++;
      if (reset_nes !== 1'b1 || run_nes !== 1'b0) begin
        n_fail++;
        $display("FAIL run_ext_reset: reset_nes=%b run_nes=%b, expected 1/0", reset_nes, run_nes);
      end
    end
    ext_reset = 1'b0;
    step();
  endtask

  task automatic test_dl_during_run();
    bus.nes_rd_cpu = 1'b1; bus.nes_rd_ppu = 1'b1;
    downloading = 1'b1; m_ovf = 1'b0;
    step();
    n_assert++;
    if (reset_nes !== 1'b1 || bus.sd_oeA !== 1'b0 || bus.sd_oeB !== 1'b0) begin
      n_fail++;
      $display("FAIL dl_takeover: reset_nes=%b oeA=%b oeB=%b, expected 1/0/0", reset_nes, bus.sd_oeA, bus.sd_oeB);
    end
    m_loader = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.ld_write = 1'b1;
      bus.ld_addr  = ADDR_W'($urandom);
      bus.ld_data  = 8'($urandom);
      step();
    end
    bus.ld_write = 1'b0;
    downloading  = 1'b0;
    for (int i = 0; i < 200 && reset_nes !== 1'b0; i++) step();
    n_assert++;
    if (reset_nes !== 1'b0 || obs_wr.size() != 2 || exp_wr.size() != 2) begin
      n_fail++;
      $display("FAIL dl_writes: reset_nes=%b, observed %0d writes, model %0d, required 2",
               reset_nes, obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      n_assert++;
      if (obs_wr[i] !== exp_wr[i]) begin
        n_fail++;
        $display("FAIL dl_write%0d: got %h, expected %h", i, obs_wr[i], exp_wr[i]);
      end
    end
    bus.nes_rd_cpu = 1'b0; bus.nes_rd_ppu = 1'b0;
    m_loader = 1'b0;
    obs_wr.delete(); obs_cyc.delete(); exp_wr.delete();
  endtask

  task automatic test_overflow();
    bit saw_full;
    saw_full = 1'b0;
    downloading = 1'b1; m_ovf = 1'b0;
    step(); step();
    m_loader = 1'b1;
    for (int i = 0; i < 4 && m_phase != 0; i++) step();
    for (int i = 0; i < 6; i++) begin
      bus.ld_write = 1'b1;
      bus.ld_addr  = ADDR_W'($urandom);
      bus.ld_data  = 8'($urandom);
      step();
      if (bus.ld_ready === 1'b0) saw_full = 1'b1;
    end
    bus.ld_write = 1'b0;
    n_assert++;
    if (bus.ld_overflow !== 1'b1 || saw_full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: ld_overflow=%b ld_ready_low_seen=%b, expected 1/1", bus.ld_overflow, saw_full);
    end
    downloading = 1'b0;
    for (int i = 0; i < 200 && reset_nes !== 1'b0; i++) step();
    n_assert++;
    if (reset_nes !== 1'b0 || obs_wr.size() != 5 || exp_wr.size() != 5) begin
      n_fail++;
      $display("FAIL ovf_writes: reset_nes=%b, observed %0d writes, model %0d, required 5",
               reset_nes, obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      n_assert++;
      if (obs_wr[i] !== exp_wr[i]) begin
        n_fail++;
        $display("FAIL ovf_write%0d: got %h, expected %h", i, obs_wr[i], exp_wr[i]);
      end
    end
    obs_wr.delete(); obs_cyc.delete(); exp_wr.delete();
    n_assert++;
    if (bus.ld_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: ld_overflow=%b in RUN, expected 1", bus.ld_overflow);
    end
    downloading = 1'b1; m_ovf = 1'b0;
    step();
    n_assert++;
    if (bus.ld_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ld_overflow=%b after new download, expected 0", bus.ld_overflow);
    end
  endtask

  task automatic test_reset_mid_download();
    step();
    for (int i = 0; i < 4 && m_phase != 0; i++) step();
    for (int i = 0; i < 2; i++) begin
      bus.ld_write = 1'b1;
      bus.ld_addr  = ADDR_W'($urandom);
      bus.ld_data  = 8'($urandom);
      step();
    end
    bus.ld_write = 1'b0;
    reset_n = 1'b0; downloading = 1'b0;
    step();
    reset_n = 1'b1;
    m_loader = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_assert++;
      if (bus.sd_we !== 1'b0 || bus.sd_addr !== '0 || reset_nes !== 1'b1 || bus.ld_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid: sd_we=%b sd_addr=%h reset_nes=%b ld_ready=%b, expected 0/0/1/1",
                 bus.sd_we, bus.sd_addr, reset_nes, bus.ld_ready);
      end
    end
    n_assert++;
    if (obs_wr.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_writes: observed %0d writes, expected 0", obs_wr.size());
    end
  endtask

  initial begin
    cyc = 0;
    last_slot_cyc = 0;
    test_reset();
    test_back_to_back();
    test_run();
    test_dl_during_run();
    test_overflow();
    test_reset_mid_download();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
